// File: rtl/ble_pkg.sv
// =============================================================================
// Module : ble_pkg
// Brief  : Shared BLE link-layer types and constants for the RX/TX byte paths.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package ble_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR0    = 3'd1,
      HDR1    = 3'd2,
      PAYLOAD = 3'd3,
      CRC     = 3'd4
   } pkt_state_e;

   localparam logic [23:0] CRC24_POLY          = 24'h00065B;
   localparam logic [23:0] ADV_CRC_INIT        = 24'h555555;
   localparam logic [31:0] ADV_ACCESS_ADDR     = 32'h8E89BED6;
   localparam int          BLE_MAX_ADV_PAYLOAD = 37;

   // Whitening seed: W[0]=1, W[1..6]=chan[5..0]; returned as W[6:0].
   function automatic logic [6:0] whiten_seed(input logic [5:0] chan);
      return {chan[0], chan[1], chan[2], chan[3], chan[4], chan[5], 1'b1};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ble_pdu_parser_if.sv
// =============================================================================
// Module : ble_pdu_parser_if
// Brief  : Byte-stream bundle between the access-address detector, the PDU
//          parser and the payload consumer.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

interface ble_pdu_parser_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;

   modport master (
      output in_data, in_valid,
      input  out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid,
      output out_data, out_valid, out_last
   );
endinterface

`default_nettype wire

// File: rtl/ble_byte_lfsr.sv
// =============================================================================
// Module : ble_byte_lfsr
// Brief  : One byte (LSB first) of BLE whitening plus CRC24, purely
//          combinational so RX de-whitening and TX whitening can share it.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module ble_byte_lfsr
   import ble_pkg::*;
#(
   parameter logic [23:0] POLY = CRC24_POLY
) (
   input  wire logic [7:0]  i_din,
   input  wire logic [6:0]  i_w,
   input  wire logic [23:0] i_c,
   input  wire logic        i_whiten,
   input  wire logic        i_crc_en,
   output logic [7:0]       o_dout,
   output logic [6:0]       o_w_next,
   output logic [23:0]      o_c_next
);

   logic [6:0]  w_w;
   logic [23:0] w_c;
   logic        w_o;
   logic        w_d;
   logic        w_fb;

   always_comb begin
      w_w    = i_w;
      w_c    = i_c;
      w_o    = 1'b0;
      w_d    = 1'b0;
      w_fb   = 1'b0;
      o_dout = 8'h00;
      for (int i = 0; i < 8; i++) begin
         w_o       = w_w[6];
         w_d       = i_din[i] ^ (w_o & i_whiten);
         o_dout[i] = w_d;
         // The whitening LFSR always steps, even in bypass, so its phase
         // stays aligned with the air bit count.
         w_w       = {w_w[5:0], w_o};
         w_w[4]    = w_w[4] ^ w_o;
         w_fb      = w_d ^ w_c[23];
         if (i_crc_en) begin
            w_c = {w_c[22:0], 1'b0} ^ (w_fb ? POLY : 24'h000000);
         end
      end
      o_w_next = w_w;
      o_c_next = w_c;
   end

endmodule

`default_nettype wire

// File: rtl/ble_pdu_parser.sv
// =============================================================================
// Module : ble_pdu_parser
// Brief  : De-whitens the post-access-address byte stream, parses the PDU
//          header, forwards the payload and checks the trailing CRC24.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module ble_pdu_parser
   import ble_pkg::*;
#(
   parameter int          MAX_PAYLOAD = BLE_MAX_ADV_PAYLOAD,
   parameter logic [23:0] CRC_POLY    = CRC24_POLY
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        i_pkt_active,
   input  wire logic [5:0]  i_chan_idx,
   input  wire logic        i_whiten_en,
   input  wire logic [23:0] i_crc_init,
   ble_pdu_parser_if.slave  bus,
   output logic             o_hdr_valid,
   output logic [3:0]       o_pdu_type,
   output logic [3:0]       o_hdr_flags,
   output logic [7:0]       o_pdu_len,
   output logic             o_pkt_done,
   output logic             o_crc_ok,
   output logic             o_len_err,
   output logic             o_abort
);

   localparam logic [2:0] c_IDLE    = IDLE;
   localparam logic [2:0] c_HDR0    = HDR0;
   localparam logic [2:0] c_HDR1    = HDR1;
   localparam logic [2:0] c_PAYLOAD = PAYLOAD;
   localparam logic [2:0] c_CRC     = CRC;
   localparam logic [7:0] c_MAX_LEN = 8'(MAX_PAYLOAD);

   logic        r_pkt_d;
   logic [2:0]  r_state;
   logic        r_whiten;
   logic [6:0]  r_w;
   logic [23:0] r_c;
   logic [23:0] r_rx;
   logic [7:0]  r_cnt;
   logic [3:0]  r_type;
   logic [3:0]  r_flags;
   logic [7:0]  r_len;
   logic        r_hdr_valid;
   logic [7:0]  r_out_data;
   logic        r_out_valid;
   logic        r_out_last;
   logic        r_pkt_done;
   logic        r_crc_ok;
   logic        r_len_err;
   logic        r_abort;

   logic        w_rise;
   logic        w_fall;
   logic        w_byte;
   logic        w_crc_en;
   logic [7:0]  w_dout;
   logic [6:0]  w_w_next;
   logic [23:0] w_c_next;
   logic [23:0] w_rx_next;

   assign w_rise   = i_pkt_active & ~r_pkt_d;
   assign w_fall   = ~i_pkt_active & r_pkt_d;
   assign w_byte   = bus.in_valid && (r_state != c_IDLE);
   assign w_crc_en = (r_state == c_HDR0) || (r_state == c_HDR1) || (r_state == c_PAYLOAD);

   // Received CRC bits are kept in air order: first bit ends up in bit 23,
   // lining up directly with the transmitted C[23]..C[0] sequence.
   assign w_rx_next = {r_rx[15:0], w_dout[0], w_dout[1], w_dout[2], w_dout[3],
                       w_dout[4], w_dout[5], w_dout[6], w_dout[7]};

   ble_byte_lfsr #(
      .POLY     (CRC_POLY)
   ) u_lfsr (
      .i_din    (bus.in_data),
      .i_w      (r_w),
      .i_c      (r_c),
      .i_whiten (r_whiten),
      .i_crc_en (w_crc_en),
      .o_dout   (w_dout),
      .o_w_next (w_w_next),
      .o_c_next (w_c_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_d     <= 1'b0;
         r_state     <= c_IDLE;
         r_whiten    <= 1'b0;
         r_w         <= 7'h00;
         r_c         <= 24'h000000;
         r_rx        <= 24'h000000;
         r_cnt       <= 8'h00;
         r_type      <= 4'h0;
         r_flags     <= 4'h0;
         r_len       <= 8'h00;
         r_hdr_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_crc_ok    <= 1'b0;
         r_len_err   <= 1'b0;
         r_abort     <= 1'b0;
      end else begin
         r_pkt_d     <= i_pkt_active;
         r_hdr_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_len_err   <= 1'b0;
         r_abort     <= 1'b0;

         if (w_rise) begin
            r_whiten <= i_whiten_en;
            r_w      <= whiten_seed(i_chan_idx);
            r_c      <= i_crc_init;
            r_rx     <= 24'h000000;
            r_cnt    <= 8'h00;
            r_crc_ok <= 1'b0;
            r_type   <= 4'h0;
            r_flags  <= 4'h0;
            r_len    <= 8'h00;
            r_state  <= c_HDR0;
         end else if (w_fall && (r_state != c_IDLE)) begin
            r_abort <= 1'b1;
            r_state <= c_IDLE;
         end else if (w_byte) begin
            r_w <= w_w_next;
            r_c <= w_c_next;
            case (r_state)
               c_HDR0: begin
                  r_type  <= w_dout[3:0];
                  r_flags <= w_dout[7:4];
                  r_state <= c_HDR1;
               end
               c_HDR1: begin
                  r_len       <= w_dout;
                  r_hdr_valid <= 1'b1;
                  r_cnt       <= w_dout;
                  if (w_dout > c_MAX_LEN) begin
                     r_len_err <= 1'b1;
                     r_state   <= c_IDLE;
                  end else if (w_dout == 8'h00) begin
                     r_state <= c_CRC;
                  end else begin
                     r_state <= c_PAYLOAD;
                  end
               end
               c_PAYLOAD: begin
                  r_out_data  <= w_dout;
                  r_out_valid <= 1'b1;
                  r_cnt       <= r_cnt - 8'd1;
                  if (r_cnt == 8'd1) begin
                     r_out_last <= 1'b1;
                     r_state    <= c_CRC;
                  end
               end
               c_CRC: begin
                  // r_cnt reaches zero on entry from either HDR1 or PAYLOAD
                  // and counts the three CRC bytes upward.
                  r_rx <= w_rx_next;
                  if (r_cnt == 8'd2) begin
                     r_pkt_done <= 1'b1;
                     r_crc_ok   <= (w_rx_next == r_c);
                     r_state    <= c_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

   assign o_hdr_valid   = r_hdr_valid;
   assign o_pdu_type    = r_type;
   assign o_hdr_flags   = r_flags;
   assign o_pdu_len     = r_len;
   assign o_pkt_done    = r_pkt_done;
   assign o_crc_ok      = r_crc_ok;
   assign o_len_err     = r_len_err;
   assign o_abort       = r_abort;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_ble_pdu_parser.sv
// =============================================================================
// Module : tb_ble_pdu_parser
// Brief  : Directed self-checking bench for ble_pdu_parser with a bit-level
//          whitening/CRC24 transmit model.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_ble_pdu_parser;
   import ble_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pkt_active = 1'b0;
   logic [5:0]  chan_idx = 6'd0;
   logic        whiten_en = 1'b0;
   logic [23:0] crc_init = ADV_CRC_INIT;
   logic        hdr_valid, pkt_done, crc_ok, len_err, abort_o;
   logic [3:0]  pdu_type, hdr_flags;
   logic [7:0]  pdu_len;

   always #5 clk = ~clk;

   ble_pdu_parser_if bus ();

   ble_pdu_parser #(
      .MAX_PAYLOAD (37),
      .CRC_POLY    (24'h00065B)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_pkt_active (pkt_active),
      .i_chan_idx   (chan_idx),
      .i_whiten_en  (whiten_en),
      .i_crc_init   (crc_init),
      .bus          (bus),
      .o_hdr_valid  (hdr_valid),
      .o_pdu_type   (pdu_type),
      .o_hdr_flags  (hdr_flags),
      .o_pdu_len    (pdu_len),
      .o_pkt_done   (pkt_done),
      .o_crc_ok     (crc_ok),
      .o_len_err    (len_err),
      .o_abort      (abort_o)
   );

   int         n_chk = 0;
   int         n_pass = 0;
   int         n_fail = 0;
   logic [7:0] pay [0:15];
   logic [7:0] expq [$];
   logic [7:0] air [$];
   logic [7:0] got [$];
   int         n_hdr, n_done, n_lenerr, n_abort, n_last, last_pos;
   logic       done_crc, lenerr_hdr;

   always @(negedge clk) begin
      if (bus.out_valid) begin
         got.push_back(bus.out_data);
         if (bus.out_last) begin
            n_last++;
            last_pos = got.size();
         end
      end
      if (hdr_valid) n_hdr++;
      if (pkt_done) begin
         n_done++;
         done_crc = crc_ok;
      end
      if (len_err) begin
         n_lenerr++;
         lenerr_hdr = hdr_valid;
      end
      if (abort_o) n_abort++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      got.delete();
      n_hdr = 0; n_done = 0; n_lenerr = 0; n_abort = 0; n_last = 0;
      last_pos = 0; done_crc = 1'b0; lenerr_hdr = 1'b0;
   endtask

   // Transmit model: CRC over plain header+payload, CRC sent MSB first,
   // optional payload bit flip after CRC, then whitening over every byte.
   task automatic build(input logic [7:0] h0, input logic [7:0] h1, input int np,
                        input logic wh, input logic [5:0] ch, input logic [23:0] init,
                        input int fidx, input logic [7:0] fmask);
      logic [23:0] c;
      logic [6:0]  w;
      logic [7:0]  b;
      logic        o, fb;
      logic [7:0]  plain [$];
      plain.delete();
      plain.push_back(h0);
      plain.push_back(h1);
      for (int i = 0; i < np; i++) plain.push_back(pay[i]);
      c = init;
      foreach (plain[k]) begin
         for (int j = 0; j < 8; j++) begin
            fb = plain[k][j] ^ c[23];
            c  = {c[22:0], 1'b0};
            if (fb) c = c ^ 24'h00065B;
         end
      end
      expq.delete();
      for (int i = 0; i < np; i++) expq.push_back(pay[i] ^ ((i == fidx) ? fmask : 8'h00));
      if (fidx >= 0) plain[2 + fidx] = plain[2 + fidx] ^ fmask;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 8; j++) b[j] = c[23 - 8 * k - j];
         plain.push_back(b);
      end
      w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
      air.delete();
      foreach (plain[k]) begin
         b = plain[k];
         for (int j = 0; j < 8; j++) begin
            o = w[6];
            if (wh) b[j] = b[j] ^ o;
            w    = {w[5:0], o};
            w[4] = w[4] ^ o;
         end
         air.push_back(b);
      end
   endtask

   task automatic start_pkt(input logic wh, input logic [5:0] ch, input logic [23:0] init);
      whiten_en  = wh;
      chan_idx   = ch;
      crc_init   = init;
      pkt_active = 1'b1;
      tick();
   endtask

   task automatic send_air(input int gap, input int n);
      for (int k = 0; k < n; k++) begin
         bus.in_data  = air[k];
         bus.in_valid = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic end_pkt();
      repeat (2) tick();
      pkt_active = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) pay[i] = 8'h3C ^ 8'(i * 37);
      clr();

      // Reset values
      repeat (3) tick();
      chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_pdu_len", 32'(pdu_len), 32'd0);
      chk("rst_crc_ok", 32'(crc_ok), 32'd0);
      chk("rst_pulses", 32'({pkt_done, len_err, abort_o, bus.out_last}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Plain packet, length 6
      clr();
      build(8'h00, 8'h06, 6, 1'b0, 6'd0, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b0, 6'd0, ADV_CRC_INIT);
      send_air(1, air.size());
      repeat (2) tick();
      chk("a_n_hdr", 32'(n_hdr), 32'd1);
      chk("a_type", 32'(pdu_type), 32'd0);
      chk("a_len", 32'(pdu_len), 32'd6);
      chk("a_nbytes", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("a_byte%0d", i), 32'(got[i]), 32'(expq[i]));
      chk("a_last_pos", 32'(last_pos), 32'd6);
      chk("a_n_last", 32'(n_last), 32'd1);
      chk("a_done", 32'(n_done), 32'd1);
      chk("a_crc_ok", 32'(done_crc), 32'd1);
      end_pkt();
      chk("a_idle_fall_no_abort", 32'(n_abort), 32'd0);
      chk("a_crc_ok_held", 32'(crc_ok), 32'd1);

      // Same packet with a corrupted payload bit, back-to-back bytes
      clr();
      build(8'h00, 8'h06, 6, 1'b0, 6'd0, ADV_CRC_INIT, 2, 8'h08);
      start_pkt(1'b0, 6'd0, ADV_CRC_INIT);
      send_air(0, air.size());
      repeat (2) tick();
      chk("b_nbytes", 32'(got.size()), 32'd6);
      chk("b_flipped", 32'(got[2]), 32'(pay[2] ^ 8'h08));
      chk("b_done", 32'(n_done), 32'd1);
      chk("b_crc_bad", 32'(done_crc), 32'd0);
      end_pkt();

      // Whitened empty PDU on channel 37
      clr();
      build(8'h00, 8'h00, 0, 1'b1, 6'd37, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b1, 6'd37, ADV_CRC_INIT);
      send_air(1, air.size());
      repeat (2) tick();
      chk("c_n_hdr", 32'(n_hdr), 32'd1);
      chk("c_len", 32'(pdu_len), 32'd0);
      chk("c_nbytes", 32'(got.size()), 32'd0);
      chk("c_done", 32'(n_done), 32'd1);
      chk("c_crc_ok", 32'(done_crc), 32'd1);
      end_pkt();

      // Length 40 exceeds the maximum
      clr();
      build(8'h05, 8'h28, 5, 1'b0, 6'd0, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b0, 6'd0, ADV_CRC_INIT);
      send_air(0, air.size());
      repeat (2) tick();
      chk("d_n_hdr", 32'(n_hdr), 32'd1);
      chk("d_type", 32'(pdu_type), 32'd5);
      chk("d_len", 32'(pdu_len), 32'h28);
      chk("d_len_err", 32'(n_lenerr), 32'd1);
      chk("d_len_err_with_hdr", 32'(lenerr_hdr), 32'd1);
      chk("d_nbytes", 32'(got.size()), 32'd0);
      chk("d_no_done", 32'(n_done), 32'd0);
      end_pkt();
      chk("d_no_abort", 32'(n_abort), 32'd0);

      // Abort after 3 of 10 payload bytes, then clean restart
      clr();
      build(8'h00, 8'h0A, 10, 1'b1, 6'd12, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b1, 6'd12, ADV_CRC_INIT);
      send_air(0, 5);
      pkt_active = 1'b0;
      repeat (2) tick();
      chk("e_abort", 32'(n_abort), 32'd1);
      chk("e_nbytes", 32'(got.size()), 32'd3);
      chk("e_byte2", 32'(got[2]), 32'(expq[2]));
      chk("e_no_done", 32'(n_done), 32'd0);
      chk("e_len_held", 32'(pdu_len), 32'd10);
      clr();
      build(8'h00, 8'h03, 3, 1'b1, 6'd12, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b1, 6'd12, ADV_CRC_INIT);
      send_air(0, air.size());
      repeat (2) tick();
      chk("e2_nbytes", 32'(got.size()), 32'd3);
      chk("e2_byte0", 32'(got[0]), 32'(expq[0]));
      chk("e2_done", 32'(n_done), 32'd1);
      chk("e2_crc_ok", 32'(done_crc), 32'd1);
      chk("e2_no_abort", 32'(n_abort), 32'd0);
      end_pkt();

      // Reset mid-payload with bytes every cycle
      clr();
      build(8'h00, 8'h0A, 10, 1'b0, 6'd0, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b0, 6'd0, ADV_CRC_INIT);
      send_air(0, 5);
      chk("f_pre_out_valid", 32'(bus.out_valid), 32'd1);
      bus.in_data  = air[5];
      bus.in_valid = 1'b1;
      rst_n        = 1'b0;
      #1;
      chk("f_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("f_rst_out_data", 32'(bus.out_data), 32'd0);
      chk("f_rst_len", 32'(pdu_len), 32'd0);
      chk("f_rst_type_flags", 32'({pdu_type, hdr_flags}), 32'd0);
      bus.in_valid = 1'b0;
      pkt_active   = 1'b0;
      tick();
      clr();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("f_no_pulse_release", 32'(n_hdr + n_done + n_abort + n_lenerr + got.size()), 32'd0);
      build(8'h01, 8'h02, 2, 1'b0, 6'd0, ADV_CRC_INIT, -1, 8'h00);
      start_pkt(1'b0, 6'd0, ADV_CRC_INIT);
      send_air(0, air.size());
      repeat (2) tick();
      chk("f2_type", 32'(pdu_type), 32'd1);
      chk("f2_len", 32'(pdu_len), 32'd2);
      chk("f2_byte1", 32'(got[1]), 32'(expq[1]));
      chk("f2_done", 32'(n_done), 32'd1);
      chk("f2_crc_ok", 32'(done_crc), 32'd1);
      end_pkt();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
